// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding and 8N1 frame constants.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam int DATA_BITS        = 8;
   localparam int STOP_BITS        = 1;
   localparam int DEFAULT_BAUD_DIV = 10417;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: loads a byte in IDLE and shifts it out LSB first between a start and a stop bit.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 busy
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam int BW = $clog2(DATA_BITS);

   tx_state_t            state, state_next;
   logic [CW-1:0]        baud_cnt, baud_cnt_next;
   logic [BW-1:0]        bit_idx, bit_idx_next;
   logic [DATA_BITS-1:0] shift, shift_next;
   logic                 tx_next, busy_next;
   logic                 baud_done, last_bit;

   assign baud_done = (baud_cnt == CW'(BAUD_DIV - 1));
   assign last_bit  = (bit_idx == BW'(DATA_BITS - 1));

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= only; a blocking write here would race the comb logic reading it.
      if (reset) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         // NOTE: the shift register is reset too; it is tiny and this keeps X out of the line in sim.
         shift    <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_cnt_next;
         bit_idx  <= bit_idx_next;
         shift    <= shift_next;
         tx       <= tx_next;
         busy     <= busy_next;
      end
   end

   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      state_next = state;
      unique case (state)
         ST_IDLE:  if (load) state_next = ST_START;
         ST_START: if (baud_done) state_next = ST_DATA;
         ST_DATA:  if (baud_done && last_bit) state_next = ST_STOP;
         ST_STOP:  if (baud_done) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Outputs are computed from the next state so tx and busy come straight out of flops.
   always_comb begin
      baud_cnt_next = (state == ST_IDLE || baud_done) ? '0 : baud_cnt + CW'(1);

      bit_idx_next = bit_idx;
      if (state == ST_DATA && baud_done)
         bit_idx_next = last_bit ? '0 : bit_idx + BW'(1);

      shift_next = shift;
      if (state == ST_IDLE && load)
         shift_next = data;
      else if (state == ST_DATA && baud_done)
         shift_next = shift >> 1;

      unique case (state_next)
         ST_START: tx_next = 1'b0;
         ST_DATA:  tx_next = shift_next[0];
         default:  tx_next = 1'b1;
      endcase

      busy_next = (state_next != ST_IDLE);
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit line between NREQ byte producers.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [8*NREQ-1:0]       req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    UART_TX,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id
);

   localparam int GW = $clog2(NREQ);

   logic [GW-1:0]   last_grant, winner;
   logic [NREQ-1:0] pick;
   logic            found, accept;
   logic [7:0]      load_data;

   // Two passes give the wrap-around search: indices above last_grant first, then the rest.
   always_comb begin
      pick      = '0;
      found     = 1'b0;
      winner    = '0;
      load_data = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (!found && req_valid[j] && j > int'(last_grant)) begin
            found     = 1'b1;
            pick[j]   = 1'b1;
            winner    = GW'(j);
            load_data = req_data[8*j +: 8];
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!found && req_valid[j] && j <= int'(last_grant)) begin
            found     = 1'b1;
            pick[j]   = 1'b1;
            winner    = GW'(j);
            load_data = req_data[8*j +: 8];
         end
      end
   end

   assign req_ready = (!busy && !reset) ? pick : '0;
   assign accept    = found && !busy && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= GW'(NREQ - 1);
         grant_id   <= '0;
      end else if (accept) begin
         last_grant <= winner;
         grant_id   <= winner;
      end
   end

   uart_tx_serializer #(
      .BAUD_DIV (BAUD_DIV)
   ) u_serializer (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .data  (load_data),
      .tx    (UART_TX),
      .busy  (busy)
   );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: expected frames are queued at accept and checked by a line decoder.
module tb_uart_tx_arbiter;

   localparam int BD = 4;
   localparam int NA = 2;
   localparam int NB = 3;

   logic            clk;
   logic            rst;
   logic [NA-1:0]   valid_a;
   logic [8*NA-1:0] data_a;
   logic [NA-1:0]   ready_a;
   logic            tx_a, busy_a;
   logic [0:0]      gid_a;
   logic [NB-1:0]   valid_b;
   logic [8*NB-1:0] data_b;
   logic [NB-1:0]   ready_b;
   logic            tx_b, busy_b;
   logic [1:0]      gid_b;

   typedef struct {
      logic [7:0] data;
      int         id;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   model_last = NA - 1;

   bit         mon_active = 0;
   bit         mon_have;
   int         mon_cnt;
   logic [7:0] mon_byte;
   exp_t       mon_exp;

   uart_tx_arbiter #(.NREQ(NA), .BAUD_DIV(BD)) dut_a (
      .clk(clk), .reset(rst), .req_valid(valid_a), .req_data(data_a),
      .req_ready(ready_a), .UART_TX(tx_a), .busy(busy_a), .grant_id(gid_a)
   );

   uart_tx_arbiter #(.NREQ(NB), .BAUD_DIV(BD)) dut_b (
      .clk(clk), .reset(rst), .req_valid(valid_b), .req_data(data_b),
      .req_ready(ready_b), .UART_TX(tx_b), .busy(busy_b), .grant_id(gid_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Round-robin reference: smallest distance after the previous winner.
   function automatic int rr_pick(input logic [NA-1:0] v, input int last);
      int best = -1;
      int best_d = NA + 1;
      for (int j = 0; j < NA; j++) begin
         if (v[j]) begin
            int d = (j - last - 1 + 2 * NA) % NA;
            if (d < best_d) begin
               best_d = d;
               best = j;
            end
         end
      end
      return best;
   endfunction

   task automatic wait_accept(input string tag, input int budget, output int t_acc);
      bit            ok = 0;
      int            w;
      logic [NA-1:0] exp_rdy;
      exp_t          e;
      t_acc = -1;
      for (int i = 0; i < budget; i++) begin
         #1;
         if ((valid_a & ready_a) != '0) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_accepted"}, 32'(ok), 1);
      if (ok) begin
         w = rr_pick(valid_a, model_last);
         exp_rdy = '0;
         if (w >= 0) exp_rdy[w] = 1'b1;
         check({tag, "_ready"}, 32'(ready_a), 32'(exp_rdy));
         if (w >= 0) begin
            e.data = data_a[8*w +: 8];
            e.id   = w;
            sb_q.push_back(e);
            model_last = w;
         end
         t_acc = cyc;
      end
   endtask

   task automatic wait_idle(input string tag);
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (busy_a === 1'b0 && !mon_active) begin
            ok = 1;
            break;
         end
      end
      check({tag, "_idle"}, 32'(ok), 1);
   endtask

   // Line decoder for dut_a: samples the middle of each bit and compares against the queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_active = 0;
         end else begin
            if (!mon_active && tx_a === 1'b0) begin
               mon_active = 1;
               mon_cnt    = 0;
               mon_byte   = '0;
               mon_have   = (sb_q.size() != 0);
               check("frame_expected", 32'(mon_have), 1);
               if (mon_have) begin
                  mon_exp = sb_q.pop_front();
                  check("frame_grant_id", 32'(gid_a), mon_exp.id);
               end
            end
            if (mon_active) begin
               if (mon_cnt % BD == BD / 2) begin
                  if (mon_cnt / BD == 0)
                     check("start_bit", 32'(tx_a), 0);
                  else if (mon_cnt / BD <= 8)
                     mon_byte[mon_cnt / BD - 1] = tx_a;
                  else begin
                     check("stop_bit", 32'(tx_a), 1);
                     if (mon_have) check("frame_byte", 32'(mon_byte), 32'(mon_exp.data));
                  end
               end
               mon_cnt++;
               if (mon_cnt == 10 * BD) mon_active = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t, t2, tprev, bad;
      int order [4] = '{2, 0, 1, 2};
      logic [NB-1:0] exp3;
      bit ok;

      rst     = 1'b1;
      valid_a = 2'b01;
      data_a  = {8'h00, 8'hA5};
      valid_b = '0;
      data_b  = {8'h33, 8'h22, 8'h11};

      // Reset, with a request already pending during the reset cycles.
      repeat (3) @(negedge clk);
      #1;
      check("rst_ready", 32'(ready_a), 0);
      check("rst_tx", 32'(tx_a), 1);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_grant_id", 32'(gid_a), 0);
      @(negedge clk);
      rst     = 1'b0;
      valid_a = '0;
      @(negedge clk);
      #1;
      check("no_accept_in_reset", 32'(busy_a), 0);

      // Single byte 0xA5 from requester 0.
      valid_a = 2'b01;
      data_a  = {8'h00, 8'hA5};
      wait_accept("single", 10, t);
      @(negedge clk);
      valid_a = '0;
      #1;
      check("single_busy_t1", 32'(busy_a), 1);
      check("single_tx_t1", 32'(tx_a), 0);
      repeat (39) @(negedge clk);
      #1;
      check("single_busy_t40", 32'(busy_a), 1);
      @(negedge clk);
      #1;
      check("single_busy_t41", 32'(busy_a), 0);
      check("single_tx_t41", 32'(tx_a), 1);
      wait_idle("single");

      // Contention: both valid continuously, grants must alternate with a 41-cycle period.
      data_a  = {8'h22, 8'h11};
      valid_a = 2'b11;
      wait_accept("cont", 60, tprev);
      for (int k = 1; k < 3; k++) begin
         @(negedge clk);
         wait_accept("cont", 60, t);
         check("cont_spacing", t - tprev, 41);
         tprev = t;
      end
      @(negedge clk);
      valid_a = '0;
      wait_idle("cont");

      // Request arriving mid-frame waits for IDLE; data changed before accept is what is sent.
      valid_a = 2'b01;
      data_a  = {8'h55, 8'h3C};
      wait_accept("late0", 10, t);
      @(negedge clk);
      valid_a = 2'b10;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (ready_a != '0) bad++;
         @(negedge clk);
      end
      check("late_ready_low", bad, 0);
      data_a = {8'h66, 8'h3C};
      wait_accept("late1", 60, t2);
      check("late_accept_cycle", t2 - t, 41);
      @(negedge clk);
      data_a  = {8'h77, 8'h3C};
      valid_a = '0;
      wait_idle("late");

      // Reset during data bit 3 aborts the frame; requester 0 wins afterwards.
      valid_a = 2'b01;
      data_a  = {8'h00, 8'hF0};
      wait_accept("abort", 10, t);
      @(negedge clk);
      valid_a = '0;
      repeat (17) @(negedge clk);
      rst = 1'b1;
      sb_q.delete();
      model_last = NA - 1;
      @(negedge clk);
      #1;
      check("abort_tx", 32'(tx_a), 1);
      check("abort_busy", 32'(busy_a), 0);
      check("abort_grant_id", 32'(gid_a), 0);
      @(negedge clk);
      rst     = 1'b0;
      valid_a = 2'b11;
      data_a  = {8'h42, 8'h81};
      wait_accept("post_rst", 10, t);
      @(negedge clk);
      valid_a = '0;
      wait_idle("post_rst");

      // Wrap-around on the three-requester instance.
      valid_b = 3'b100;
      for (int i = 0; i < 4; i++) begin
         ok = 0;
         for (int c = 0; c < 60; c++) begin
            #1;
            if ((valid_b & ready_b) != '0) begin
               ok = 1;
               break;
            end
            @(negedge clk);
         end
         check("wrap_accepted", 32'(ok), 1);
         exp3 = '0;
         exp3[order[i]] = 1'b1;
         check("wrap_ready", 32'(ready_b), 32'(exp3));
         @(negedge clk);
         valid_b = 3'b111;
         #1;
         check("wrap_grant_id", 32'(gid_b), order[i]);
      end
      valid_b = '0;

      check("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
